// File: rtl/dispensador_pkg.sv
// Shared definitions for the dispenser arbiter: FSM state encoding and parameter defaults.
package dispensador_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACIONAR = 2'd1,
        ESPERA  = 2'd2,
        ALARME  = 2'd3
    } state_t;

    localparam int unsigned N_REQ_DEF        = 4;
    localparam int unsigned TIMEOUT_CYC_DEF  = 100;
    localparam int unsigned COOLDOWN_CYC_DEF = 4;

    // Counter width able to hold the larger of the two cycle limits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin selector: first active request at or above ptr, with wrap.
module arbitro_rr #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    winner,
    output logic             any
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!any && req[idx[PW-1:0]]) begin
                winner = idx[PW-1:0];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_dispensador.sv
// Round-robin dispenser arbiter with cooldown and alarm handling.
// Optional ACIONAR timeout enabled by defining ARBITRO_TIMEOUT_EN.
module arbitro_dispensador
    import dispensador_pkg::*;
#(
    parameter int unsigned N_REQ        = N_REQ_DEF,
    parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
    parameter int unsigned COOLDOWN_CYC = COOLDOWN_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic                     mc,
    input  logic                     bz,
    input  logic                     clr_alarm,
    output logic                     act,
    output logic [N_REQ-1:0]         gnt,
    output logic                     alarm,
    output logic                     busy,
    output logic                     served,
    output logic [$clog2(N_REQ)-1:0] served_id
);

    localparam int unsigned PW = $clog2(N_REQ);
    localparam int unsigned CW = cnt_width(TIMEOUT_CYC, COOLDOWN_CYC);
    localparam logic [CW-1:0]    CD_LAST = CW'(COOLDOWN_CYC - 1);
    localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);
    localparam logic [PW-1:0]    LAST_ID = PW'(N_REQ - 1);
`ifdef ARBITRO_TIMEOUT_EN
    localparam logic [CW-1:0]    TO_LAST = CW'(TIMEOUT_CYC - 1);
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cur;
    logic [PW-1:0] winner;
    logic          any;

    arbitro_rr #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            cur       <= '0;
            act       <= 1'b0;
            gnt       <= '0;
            alarm     <= 1'b0;
            busy      <= 1'b0;
            served    <= 1'b0;
            served_id <= '0;
        end else begin
            served <= 1'b0;
            // Alarm input overrides everything, including a confirmation on the same edge.
            if (bz) begin
                state <= ALARME;
                cnt   <= '0;
                act   <= 1'b0;
                gnt   <= '0;
                alarm <= 1'b1;
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (any) begin
                            state <= ACIONAR;
                            cnt   <= '0;
                            cur   <= winner;
                            gnt   <= ONE << winner;
                            act   <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                    ACIONAR: begin
                        if (mc) begin
                            state     <= ESPERA;
                            cnt       <= '0;
                            act       <= 1'b0;
                            gnt       <= '0;
                            served    <= 1'b1;
                            served_id <= cur;
                            ptr       <= (cur == LAST_ID) ? '0 : cur + 1'b1;
                        end
`ifdef ARBITRO_TIMEOUT_EN
                        else if (cnt == TO_LAST) begin
                            state <= ALARME;
                            cnt   <= '0;
                            act   <= 1'b0;
                            gnt   <= '0;
                            alarm <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                    ESPERA: begin
                        if (cnt == CD_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ALARME: begin
                        if (clr_alarm) begin
                            state <= IDLE;
                            cnt   <= '0;
                            alarm <= 1'b0;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arbitro_dispensador.sv
// Directed self-checking bench for arbitro_dispensador (default parameters).
// Timeout behaviour checked according to whether ARBITRO_TIMEOUT_EN is defined.
module tb_arbitro_dispensador;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       mc;
    logic       bz;
    logic       clr_alarm;
    logic       act;
    logic [3:0] gnt;
    logic       alarm;
    logic       busy;
    logic       served;
    logic [1:0] served_id;

    int total;
    int bad;

    arbitro_dispensador #(
        .N_REQ        (4),
        .TIMEOUT_CYC  (100),
        .COOLDOWN_CYC (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mc        (mc),
        .bz        (bz),
        .clr_alarm (clr_alarm),
        .act       (act),
        .gnt       (gnt),
        .alarm     (alarm),
        .busy      (busy),
        .served    (served),
        .served_id (served_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, ".act"}, 32'(act), 32'd0);
        chk({tag, ".gnt"}, 32'(gnt), 32'd0);
        chk({tag, ".alarm"}, 32'(alarm), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".served"}, 32'(served), 32'd0);
        chk({tag, ".served_id"}, 32'(served_id), 32'd0);
    endtask

    logic [3:0] exp_gnt [4];

    initial begin
        total = 0;
        bad   = 0;
        exp_gnt[0] = 4'b0001;
        exp_gnt[1] = 4'b0010;
        exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000;

        reset = 1'b1; req = '0; mc = 1'b0; bz = 1'b0; clr_alarm = 1'b0;
        step();
        step();
        chk_all_idle("reset");
        reset = 1'b0;

        // Single dispense for requester 1, with req dropped mid-dispense.
        req = 4'b0010;
        step();
        chk("single.gnt", 32'(gnt), 32'b0010);
        chk("single.act", 32'(act), 32'd1);
        chk("single.busy", 32'(busy), 32'd1);
        req = 4'b0000;
        repeat (3) step();
        chk("single.hold_gnt", 32'(gnt), 32'b0010);
        chk("single.hold_act", 32'(act), 32'd1);
        mc = 1'b1;
        step();
        mc = 1'b0;
        chk("single.served", 32'(served), 32'd1);
        chk("single.served_id", 32'(served_id), 32'd1);
        chk("single.act_off", 32'(act), 32'd0);
        chk("single.gnt_off", 32'(gnt), 32'd0);
        step();
        chk("single.served_pulse", 32'(served), 32'd0);
        chk("single.id_held", 32'(served_id), 32'd1);
        step();
        step();
        chk("single.espera_busy", 32'(busy), 32'd1);
        step();
        chk("single.idle_busy", 32'(busy), 32'd0);

        // Round-robin over four dispenses from ptr=0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr.gnt", 32'(gnt), 32'(exp_gnt[i]));
            mc = 1'b1;
            step();
            mc = 1'b0;
            chk("rr.served", 32'(served), 32'd1);
            chk("rr.served_id", 32'(served_id), 32'(i));
            repeat (4) step();
        end
        chk("rr.idle_after", 32'(busy), 32'd0);

        // bz aborts a dispense to requester 2; alarm clears only with bz low.
        req = 4'b0100;
        step();
        chk("bz.gnt", 32'(gnt), 32'b0100);
        bz = 1'b1;
        step();
        chk("bz.alarm", 32'(alarm), 32'd1);
        chk("bz.act", 32'(act), 32'd0);
        chk("bz.gnt_off", 32'(gnt), 32'd0);
        chk("bz.no_served", 32'(served), 32'd0);
        chk("bz.served_id_held", 32'(served_id), 32'd3);
        bz = 1'b0;
        step();
        chk("bz.stay", 32'(alarm), 32'd1);
        clr_alarm = 1'b1; bz = 1'b1;
        step();
        chk("bz.clr_blocked", 32'(alarm), 32'd1);
        bz = 1'b0;
        step();
        clr_alarm = 1'b0;
        chk("bz.cleared_alarm", 32'(alarm), 32'd0);
        chk("bz.cleared_busy", 32'(busy), 32'd0);
        step();
        chk("bz.regrant", 32'(gnt), 32'b0100);

        // mc and bz together: bz wins, no served, ptr stays at 0.
        mc = 1'b1; bz = 1'b1;
        step();
        mc = 1'b0; bz = 1'b0;
        chk("mcbz.alarm", 32'(alarm), 32'd1);
        chk("mcbz.served", 32'(served), 32'd0);
        clr_alarm = 1'b1;
        step();
        clr_alarm = 1'b0;
        req = 4'b1111;
        step();
        req = 4'b0000;
        chk("mcbz.ptr_kept", 32'(gnt), 32'b0001);

        // No confirmation: timeout behaviour depends on the build macro.
`ifdef ARBITRO_TIMEOUT_EN
        repeat (99) step();
        chk("tout.act_cycle100", 32'(act), 32'd1);
        chk("tout.no_alarm_yet", 32'(alarm), 32'd0);
        step();
        chk("tout.act_off", 32'(act), 32'd0);
        chk("tout.alarm", 32'(alarm), 32'd1);
`else
        repeat (210) step();
        chk("notout.act", 32'(act), 32'd1);
        chk("notout.alarm", 32'(alarm), 32'd0);
        chk("notout.gnt", 32'(gnt), 32'b0001);
`endif

        // Reset wins over an active state, then over bz mid-ESPERA.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_idle("rst_mid");
        req = 4'b0100;
        step();
        req = 4'b0000;
        mc = 1'b1;
        step();
        mc = 1'b0;
        chk("espera.served_id", 32'(served_id), 32'd2);
        step();
        chk("espera.busy", 32'(busy), 32'd1);
        reset = 1'b1; bz = 1'b1; req = 4'b1111;
        step();
        chk_all_idle("rst_espera");
        reset = 1'b0; bz = 1'b0;
        step();
        chk("rst.ptr_zero", 32'(gnt), 32'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
